// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Command sequencer that sits in front of a 4-bit universal shift register.
// A rising edge on start captures a load word, a direction, a step count and
// a fill bit. The sequencer then issues one LOAD command followed by
// `steps` SHIFT commands. Each command is held for HOLD_CYCLES clocks so that
// the shift register's divided clock samples it exactly once.
//
// Optional feature macro: SEQ_RETURN_EN
//   When defined, every SHIFT phase is followed by a RETURN phase of equal
//   length in the opposite direction. When undefined, SHIFT goes to DONE.
//
// Parameters
//   HOLD_CYCLES : clocks per issued command (>= 1); equals the register's
//                 slow-clock period
//   CNT_W       : hold/step counter width (derived, not meant to be overridden)
//
// Ports
//   Inclk          in  : system clock
//   reset          in  : synchronous, active-high reset
//   start          in  : level input, rising edge starts a sequence
//   load_data[3:0] in  : parallel word, bit k drives Ik
//   dir            in  : 0 shift toward Q0, 1 shift toward Q3
//   steps[2:0]     in  : number of shift commands (0..7)
//   fill           in  : serial bit presented on the active serial input
//   s1, s0         out : mode select 00 hold, 01 load, 10 to Q0, 11 to Q3
//   I0..I3         out : parallel data to the register
//   shr_in         out : serial input feeding Q3 in mode 10
//   shl_in         out : serial input feeding Q0 in mode 11
//   busy           out : high while a command sequence is in progress
//   done           out : single-cycle completion pulse
//
// All outputs are registered and only change on state transitions.
// -----------------------------------------------------------------------------
module shift_sequencer #(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int CNT_W       = $clog2(HOLD_CYCLES*8+1)
) (
   input  logic       Inclk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] load_data,
   input  logic       dir,
   input  logic [2:0] steps,
   input  logic       fill,
   output logic       s1,
   output logic       s0,
   output logic       I0,
   output logic       I1,
   output logic       I2,
   output logic       I3,
   output logic       shr_in,
   output logic       shl_in,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
`ifdef SEQ_RETURN_EN
      S_RETURN,
`endif
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_start_q;
   logic [3:0]       r_data;
   logic             r_dir;
   logic [2:0]       r_steps;
   logic             r_fill;

   logic             w_start_edge;
   logic             w_cnt_zero;
   logic [CNT_W-1:0] w_shift_m1;

   assign w_start_edge = start & ~r_start_q;
   assign w_cnt_zero   = (r_cnt == '0);
   // Duration of one shift phase minus one. Only used when the captured step
   // count is non-zero, so the subtraction never underflows where it matters.
   assign w_shift_m1   = CNT_W'(r_steps) * CNT_W'(HOLD_CYCLES) - CNT_W'(1);

   // The start history follows the pin even while reset is held, so a start
   // level that is already high when reset releases is not mistaken for an
   // edge. With start low during reset this is 0, the documented reset value.
   always_ff @(posedge Inclk) begin
      r_start_q <= start;
   end

   always_ff @(posedge Inclk) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_data           <= '0;
         r_dir            <= 1'b0;
         r_steps          <= '0;
         r_fill           <= 1'b0;
         {s1, s0}         <= 2'b00;
         {I3, I2, I1, I0} <= 4'b0000;
         shr_in           <= 1'b0;
         shl_in           <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (w_start_edge) begin
                  // Shadow copies: later input changes are ignored until the
                  // next accepted edge.
                  r_data           <= load_data;
                  r_dir            <= dir;
                  r_steps          <= steps;
                  r_fill           <= fill;
                  r_state          <= S_LOAD;
                  r_cnt            <= HOLD_M1;
                  {s1, s0}         <= 2'b01;
                  {I3, I2, I1, I0} <= load_data;
                  shr_in           <= 1'b0;
                  shl_in           <= 1'b0;
                  busy             <= 1'b1;
               end
            end

            S_LOAD: begin
               if (w_cnt_zero) begin
                  if (r_steps != 3'd0) begin
                     r_state  <= S_SHIFT;
                     r_cnt    <= w_shift_m1;
                     {s1, s0} <= {1'b1, r_dir};
                     // Fill goes on the serial input that feeds the vacated end.
                     shr_in   <= ~r_dir & r_fill;
                     shl_in   <=  r_dir & r_fill;
                  end else begin
                     r_state          <= S_DONE;
                     {s1, s0}         <= 2'b00;
                     {I3, I2, I1, I0} <= 4'b0000;
                     busy             <= 1'b0;
                     done             <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_SHIFT: begin
               if (w_cnt_zero) begin
`ifdef SEQ_RETURN_EN
                  r_state  <= S_RETURN;
                  r_cnt    <= w_shift_m1;
                  {s1, s0} <= {1'b1, ~r_dir};
                  shr_in   <=  r_dir & r_fill;
                  shl_in   <= ~r_dir & r_fill;
`else
                  r_state          <= S_DONE;
                  {s1, s0}         <= 2'b00;
                  {I3, I2, I1, I0} <= 4'b0000;
                  shr_in           <= 1'b0;
                  shl_in           <= 1'b0;
                  busy             <= 1'b0;
                  done             <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

`ifdef SEQ_RETURN_EN
            S_RETURN: begin
               if (w_cnt_zero) begin
                  r_state          <= S_DONE;
                  {s1, s0}         <= 2'b00;
                  {I3, I2, I1, I0} <= 4'b0000;
                  shr_in           <= 1'b0;
                  shl_in           <= 1'b0;
                  busy             <= 1'b0;
                  done             <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`endif

            S_DONE: begin
               // A start edge seen here is dropped, not queued.
               r_state <= S_IDLE;
               done    <= 1'b0;
            end

            default: begin
               r_state          <= S_IDLE;
               r_cnt            <= '0;
               {s1, s0}         <= 2'b00;
               {I3, I2, I1, I0} <= 4'b0000;
               shr_in           <= 1'b0;
               shl_in           <= 1'b0;
               busy             <= 1'b0;
               done             <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Bench for shift_sequencer with HOLD_CYCLES = 4. A table of start requests is
// expanded into a per-cycle expected output trace that is pushed into a
// scoreboard queue when the request is driven; every following cycle pops one
// entry and compares it with the sampled outputs. A few hand-written runs
// cover reset, mid-sequence restart attempts, a start edge in the DONE cycle
// and reset in the middle of SHIFT. Compile with +define+SEQ_RETURN_EN to
// exercise the RETURN phase.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

   localparam int H = 4;

   logic       Inclk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] load_data;
   logic       dir;
   logic [2:0] steps;
   logic       fill;
   logic       s1, s0, I0, I1, I2, I3, shr_in, shl_in, busy, done;

   shift_sequencer #(.HOLD_CYCLES(H)) dut (
      .Inclk(Inclk), .reset(reset), .start(start), .load_data(load_data),
      .dir(dir), .steps(steps), .fill(fill), .s1(s1), .s0(s0),
      .I0(I0), .I1(I1), .I2(I2), .I3(I3), .shr_in(shr_in), .shl_in(shl_in),
      .busy(busy), .done(done)
   );

   always #5 Inclk = ~Inclk;

   // Expected record layout: {s1,s0,I3,I2,I1,I0,shr_in,shl_in,busy,done}
   typedef struct {
      logic [3:0] data;
      logic       dir;
      logic [2:0] steps;
      logic       fill;
      int         done_off;   // sample index of done, first LOAD sample = 1
   } vec_t;

   vec_t       tbl [5];
   logic [9:0] q [$];
   int         checks = 0;
   int         errors = 0;

   function automatic logic [9:0] outs();
      return {s1, s0, I3, I2, I1, I0, shr_in, shl_in, busy, done};
   endfunction

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   // Builds the expected trace from the documented output of each phase.
   // mode 3 models a reset asserted in the second SHIFT cycle.
   task automatic push_trace(input vec_t v, input int mode);
      int n;
      for (int i = 0; i < H; i++) q.push_back({2'b01, v.data, 2'b00, 2'b10});
      n = (mode == 3) ? 2 : int'(v.steps) * H;
      for (int i = 0; i < n; i++)
         q.push_back({1'b1, v.dir, v.data, ~v.dir & v.fill, v.dir & v.fill, 2'b10});
      if (mode == 3) begin
         for (int i = 0; i < 3; i++) q.push_back(10'b0);
         return;
      end
`ifdef SEQ_RETURN_EN
      for (int i = 0; i < n; i++)
         q.push_back({1'b1, ~v.dir, v.data, v.dir & v.fill, ~v.dir & v.fill, 2'b10});
`endif
      q.push_back(10'b00_0000_00_01);
      for (int i = 0; i < 3; i++) q.push_back(10'b0);
   endtask

   // mode 0 plain, 1 restart attempt mid-SHIFT, 2 start edge in DONE cycle,
   // 3 reset in second SHIFT cycle
   task automatic run_seq(input string nm, input vec_t v, input int mode);
      int off, dones;
      push_trace(v, mode);
      @(negedge Inclk);
      load_data = v.data; dir = v.dir; steps = v.steps; fill = v.fill;
      start = 1'b1;
      off = 0; dones = 0;
      while (q.size() > 0 && off < 200) begin
         @(negedge Inclk);
         off++;
         chk(nm, outs(), q.pop_front());
         if (done) begin
            dones++;
            chk_int({nm, " done_off"}, off, v.done_off);
         end
         if (off == 1) start = 1'b0;
         if (mode == 1 && off == H + 2) begin
            start = 1'b1; load_data = ~v.data; dir = ~v.dir; steps = 3'd0; fill = ~v.fill;
         end
         if (mode == 1 && off == H + 3) start = 1'b0;
         if (mode == 2 && off == v.done_off)     start = 1'b1;
         if (mode == 2 && off == v.done_off + 1) start = 1'b0;
         if (mode == 3 && off == H + 2) reset = 1'b1;
         if (mode == 3 && off == H + 3) reset = 1'b0;
      end
      if (off >= 200) begin
         errors++;
         $display("FAIL %s timeout with %0d entries left", nm, q.size());
         q.delete();
      end
      chk_int({nm, " dones"}, dones, (mode == 3) ? 0 : 1);
      start = 1'b0;
   endtask

   initial begin
`ifdef SEQ_RETURN_EN
      tbl[0] = '{4'b1011, 1'b0, 3'd0, 1'b0,  5};
      tbl[1] = '{4'b0001, 1'b1, 3'd3, 1'b1, 29};
      tbl[2] = '{4'b1100, 1'b0, 3'd2, 1'b0, 21};
      tbl[3] = '{4'b0110, 1'b1, 3'd7, 1'b0, 61};
      tbl[4] = '{4'b1111, 1'b0, 3'd1, 1'b1, 13};
`else
      tbl[0] = '{4'b1011, 1'b0, 3'd0, 1'b0,  5};
      tbl[1] = '{4'b0001, 1'b1, 3'd3, 1'b1, 17};
      tbl[2] = '{4'b1100, 1'b0, 3'd2, 1'b0, 13};
      tbl[3] = '{4'b0110, 1'b1, 3'd7, 1'b0, 33};
      tbl[4] = '{4'b1111, 1'b0, 3'd1, 1'b1,  9};
`endif

      // Reset held with start high; start stays high after release.
      reset = 1'b1; start = 1'b1;
      load_data = 4'b1010; dir = 1'b0; steps = 3'd2; fill = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Inclk);
         chk("reset_hold", outs(), 10'b0);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Inclk);
         chk("post_reset_start_high", outs(), 10'b0);
      end
      start = 1'b0;
      repeat (2) @(negedge Inclk);

      for (int i = 0; i < 5; i++) run_seq($sformatf("vec%0d", i), tbl[i], 0);

      run_seq("restart_mid_shift", tbl[1], 1);
      run_seq("start_in_done", tbl[4], 2);
      run_seq("reset_mid_shift", tbl[1], 3);
      // Sequencer must still work normally after the mid-run reset.
      run_seq("after_reset", tbl[2], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

- Upstream command sequencer for the 4-bit universal shift register; drives its `s1`, `s0`, `I0`–`I3`, `shr_in` and `shl_in` inputs.
- On a start request it captures a load word, direction, step count and fill bit. It then issues one LOAD command followed by a programmed number of SHIFT commands.
- Each command is held for `HOLD_CYCLES` clocks so the shift register's divided clock samples it.
- Runs on the same board clock as the shift register; sits between the user inputs and the shift register.

## Interface
Parameters:
- `HOLD_CYCLES`, default 25_000_000 — clocks per issued command. Must equal the shift register's slow-clock period. Minimum 1.
- `CNT_W`, default $clog2(HOLD_CYCLES*8+1) — hold/step counter width. Derived; not overridden.

Ports:
- `Inclk` in 1 — system clock. One clock only.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — level input, rising-edge detected internally.
- `load_data` in 4 — parallel word; bit k drives `Ik`.
- `dir` in 1 — 0: shift toward Q0; 1: shift toward Q3.
- `steps` in 3 — number of shift commands, 0–7.
- `fill` in 1 — serial bit presented on the active serial input.
- `s1`, `s0` out 1 each — mode select: 00 hold, 01 load, 10 shift toward Q0, 11 shift toward Q3.
- `I0`, `I1`, `I2`, `I3` out 1 each — parallel data to the register.
- `shr_in`, `shl_in` out 1 each — serial inputs. `shr_in` feeds Q3 in mode 10; `shl_in` feeds Q0 in mode 11.
- `busy` out 1 — high while a command sequence is in progress.
- `done` out 1 — single-cycle completion pulse.

## Operation
- Every output is registered.
- Reset values: all outputs 0, i.e. mode 00 (hold), busy=0, done=0. Internally: state IDLE, counters 0, `start_q`=0.
- Start edge: `start_q` is registered every cycle; edge = `start & ~start_q`. An edge is ignored in every state except IDLE and is not queued.
- On an accepted edge, `load_data`, `dir`, `steps` and `fill` are captured into shadow registers. Later input changes have no effect until the next accepted edge.

States:
- IDLE — mode 00, busy=0.
  - On start edge → LOAD.
- LOAD — mode 01, `I3..I0` = captured data, serial outputs 0, busy=1.
  - Held exactly `HOLD_CYCLES` cycles.
  - Then → SHIFT if captured steps ≠ 0, else → DONE.
- SHIFT — mode 10 if dir=0, mode 11 if dir=1. The active serial output carries the captured fill bit; the inactive serial output is 0. `I3..I0` keep the captured data. busy=1.
  - Held exactly steps × `HOLD_CYCLES` cycles.
  - Then → RETURN if `SEQ_RETURN_EN` is defined, else → DONE.
- RETURN (compiled only with `SEQ_RETURN_EN`) — same as SHIFT but with the opposite direction, mode 11↔10. The fill bit moves to the other serial output. Same duration as SHIFT, then → DONE.
- DONE — mode 00, done=1, busy=0, for one cycle → IDLE.
  - A start edge arriving in the DONE cycle is ignored.

Counter rules:
- A single down-counter is loaded on each state entry with the state's duration minus 1; the state exits when the counter reaches 0.
- No wrap-around: the counter never decrements below 0.

Reset mid-operation: the state returns to IDLE on the next edge and outputs return to reset values. No done pulse is produced.

## Timing
- Start edge detected at cycle n (`start` high at edge n, low at edge n−1) → outputs show mode 01 from cycle n+1.
- LOAD occupies cycles n+1 … n+H, where H = `HOLD_CYCLES`.
- SHIFT occupies the next steps × H cycles.
- `done`=1 at cycle n+1+H·(1+steps), or n+1+H·(1+2·steps) with `SEQ_RETURN_EN`.
- busy rises at n+1 and falls in the same cycle `done` rises.
- Earliest next accepted edge: the cycle after DONE.
- Mode and data outputs change only on state transitions, never mid-hold.

## Configuration
- `SEQ_RETURN_EN` defined: RETURN state is present. Every shift sequence is followed by an equal number of opposite-direction shifts. With fill equal to the bits shifted out, the word returns to its loaded value.
- `SEQ_RETURN_EN` undefined: the RETURN state and its logic are absent; SHIFT goes directly to DONE.

## Test plan
All scenarios use `HOLD_CYCLES`=4.
1. Reset held 3 cycles, start=1 during reset → all outputs 0 throughout and one cycle after release. Leaving start=1 after release produces no sequence.
2. load_data=4'b1011, steps=0, start edge at cycle 10:
   - cycles 11–14: mode 01 with I3..I0=1011.
   - cycle 15: done=1, mode 00.
   - busy high 11–14 only.
3. load_data=4'b0001, dir=1, steps=3, fill=1, `SEQ_RETURN_EN` off:
   - mode 11 with shl_in=1, shr_in=0 for exactly 12 cycles after LOAD.
   - done at edge+17.
4. Start toggled 0→1 again mid-SHIFT and `load_data` changed → no restart. Outputs keep the originally captured values; exactly one done pulse.
5. Reset asserted in SHIFT cycle 2 of scenario 3 → next cycle all outputs 0, state IDLE, no done.
6. `SEQ_RETURN_EN` on, dir=0, steps=2, fill=0:
   - mode 10 (shr_in=0) for 8 cycles.
   - then mode 11 (shl_in=0) for 8 cycles.
   - done at edge+21.
